// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the 8-bit combinational ALU. Each accepted
//   ALU result (result, NZVC, ALU_Sel) goes into a 2-entry FIFO that is drained
//   by the consumer through a valid/ready handshake. The stage also keeps the
//   architectural NZVC flag register and sticky {V,C} bits for branch/compare.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready        producer handshake (in_ready = count != 2)
//   in_result/nzvc/sel       ALU result, {N,Z,V,C}, ALU_Sel ([2]=1 logic op)
//   out_valid/out_ready      consumer handshake (out_valid = count != 0)
//   out_result/nzvc/sel      head entry, all zero when empty
//   flags                    architectural NZVC register
//   sticky                   sticky {V,C}
//   clear_sticky             synchronous clear of sticky
//   count                    occupancy 0..2
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_nzvc,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzvc,
  output logic [2:0]       out_sel,
  output logic [3:0]       flags,
  output logic [1:0]       sticky,
  input  logic             clear_sticky,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       nzvc;
    logic [2:0]       sel;
  } entry_t;

  entry_t mem [2];
  logic   wr_ptr, rd_ptr;
  logic   push, pop, arith;
  entry_t head, wr_data;

  // Handshake status comes from the registered count only.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign arith     = ~in_sel[2];
  assign wr_data   = '{result: in_result, nzvc: in_nzvc, sel: in_sel};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Flags follow program order at accept time. Logic ops leave V/C alone
  // since the ALU zeroes them for those ops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags  <= 4'b0100;
      sticky <= 2'b00;
    end else begin
      if (push) begin
        if (arith) flags <= in_nzvc;
        else       flags[3:2] <= in_nzvc[3:2];
      end
      // Clear first, then OR in this cycle's arithmetic event so it survives.
      sticky <= (clear_sticky ? 2'b00 : sticky)
              | ((push && arith) ? in_nzvc[1:0] : 2'b00);
    end
  end

  // Empty outputs are masked through count; storage keeps stale data.
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_result = head.result;
  assign out_nzvc   = head.nzvc;
  assign out_sel    = head.sel;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, clear_sticky = 1'b0;
  logic [7:0] in_result = '0;
  logic [3:0] in_nzvc = '0;
  logic [2:0] in_sel = '0;
  logic       in_ready, out_valid;
  logic [7:0] out_result;
  logic [3:0] out_nzvc, flags;
  logic [2:0] out_sel;
  logic [1:0] sticky, count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_stage #(.WIDTH(8), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nzvc(in_nzvc), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_nzvc(out_nzvc), .out_sel(out_sel),
    .flags(flags), .sticky(sticky), .clear_sticky(clear_sticky),
    .count(count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of accepted entries plus flag/sticky registers.
  typedef struct {
    logic [7:0] result;
    logic [3:0] nzvc;
    logic [2:0] sel;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_flags  = 4'b0100;
  logic [1:0] m_sticky = 2'b00;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_flags  = 4'b0100;
      m_sticky = 2'b00;
    end else begin
      bit acc, take;
      ent_t e;
      acc  = in_valid && (q.size() < 2);
      take = out_ready && (q.size() > 0);
      if (take) void'(q.pop_front());
      if (acc) begin
        e.result = in_result; e.nzvc = in_nzvc; e.sel = in_sel;
        q.push_back(e);
        if (in_sel[2]) m_flags[3:2] = in_nzvc[3:2];
        else           m_flags      = in_nzvc;
      end
      if (clear_sticky) m_sticky = 2'b00;
      if (acc && !in_sel[2]) m_sticky = m_sticky | in_nzvc[1:0];
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    ent_t h;
    if (q.size() > 0) h = q[0];
    else begin h.result = '0; h.nzvc = '0; h.sel = '0; end
    check("m_count",     32'(count),      32'(q.size()));
    check("m_in_ready",  32'(in_ready),   32'(q.size() < 2));
    check("m_out_valid", 32'(out_valid),  32'(q.size() > 0));
    check("m_out_result",32'(out_result), 32'(h.result));
    check("m_out_nzvc",  32'(out_nzvc),   32'(h.nzvc));
    check("m_out_sel",   32'(out_sel),    32'(h.sel));
    check("m_flags",     32'(flags),      32'(m_flags));
    check("m_sticky",    32'(sticky),     32'(m_sticky));
  end

  task automatic drive(input logic v, input logic [7:0] r, input logic [3:0] f, input logic [2:0] s);
    in_valid = v; in_result = r; in_nzvc = f; in_sel = s;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"},     32'(count),      32'd0);
    check({tag, "_in_ready"},  32'(in_ready),   32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    check({tag, "_flags"},     32'(flags),      32'h4);
    check({tag, "_sticky"},    32'(sticky),     32'd0);
    check({tag, "_out_result"},32'(out_result), 32'h00);
  endtask

  task automatic scen2(input string tag);
    out_ready = 1'b0;
    drive(1'b1, 8'h80, 4'b1010, 3'b000);
    step();
    drive(1'b0, 8'h00, 4'b0000, 3'b000);
    check({tag, "_out_valid"}, 32'(out_valid),  32'd1);
    check({tag, "_out_result"},32'(out_result), 32'h80);
    check({tag, "_flags"},     32'(flags),      32'b1010);
    check({tag, "_sticky"},    32'(sticky),     32'b10);
    check({tag, "_count"},     32'(count),      32'd1);
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) step();
    RST = 1'b0;
    step();
    check_reset_vals("idle");

    // 2: single arithmetic push, held at head
    scen2("push1");
    step();
    check("hold_out_result", 32'(out_result), 32'h80);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("drain1_count", 32'(count), 32'd0);

    // 3: fill, back-pressure, ordered drain
    drive(1'b1, 8'h11, 4'b0000, 3'b001); step();
    drive(1'b1, 8'h22, 4'b0000, 3'b010); step();
    drive(1'b1, 8'h33, 4'b0000, 3'b011); step();
    check("full_in_ready", 32'(in_ready),   32'd0);
    check("full_count",    32'(count),      32'd2);
    check("full_head",     32'(out_result), 32'h11);
    out_ready = 1'b1; step();
    check("pop11_head",     32'(out_result), 32'h22);
    check("pop11_in_ready", 32'(in_ready),   32'd1);
    step();
    drive(1'b0, 8'h00, 4'b0000, 3'b000);
    check("acc33_head",  32'(out_result), 32'h33);
    check("acc33_count", 32'(count),      32'd1);
    step(); out_ready = 1'b0;
    check("drain3_count", 32'(count), 32'd0);

    // 4: simultaneous push/pop at count=1, pointer wrap
    drive(1'b1, 8'h55, 4'b1000, 3'b000); step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h44 + 8'(i), 4'b0000, 3'b000);
      step();
      check("pp_count", 32'(count),      32'd1);
      check("pp_head",  32'(out_result), 32'h44 + i);
    end
    drive(1'b0, 8'h00, 4'b0000, 3'b000);
    step(); out_ready = 1'b0;

    // 5: logic op keeps V/C, clear_sticky with same-cycle event
    out_ready = 1'b1;
    drive(1'b1, 8'h03, 4'b0011, 3'b001); step();
    check("arith_flags", 32'(flags), 32'b0011);
    drive(1'b1, 8'h0f, 4'b0100, 3'b100); step();
    check("logic_flags",  32'(flags),  32'b0111);
    check("logic_sticky", 32'(sticky), 32'b11);
    check("logic_sel",    32'(out_sel), 32'b100);
    drive(1'b1, 8'h01, 4'b0001, 3'b000); clear_sticky = 1'b1; step();
    check("clr_sticky", 32'(sticky), 32'b01);
    check("clr_flags",  32'(flags),  32'b0001);
    drive(1'b0, 8'h00, 4'b0000, 3'b000); clear_sticky = 1'b0;
    step(); out_ready = 1'b0;

    // 6: async reset mid-cycle while full
    drive(1'b1, 8'hA1, 4'b0011, 3'b000); step();
    drive(1'b1, 8'hA2, 4'b0000, 3'b000); step();
    drive(1'b0, 8'h00, 4'b0000, 3'b000);
    check("pre_rst_count", 32'(count), 32'd2);
    #2 RST = 1'b1;
    #1 check_reset_vals("async_rst");
    step();
    RST = 1'b0;
    step();
    scen2("post_rst");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 8-bit combinational ALU. It captures Result, NZVC and the ALU_Sel value that produced them into a 2-entry FIFO with a valid/ready handshake toward the consumer (register-file writeback / bus).
- It also holds the architectural NZVC flag register and sticky overflow/carry bits that later branch and compare logic reads.

Parameters:
- WIDTH, 8, datapath width; fixed to the ALU width, no other value supported.
- DEPTH, 2, FIFO entries; fixed at 2, so the pointer logic is 1 bit and the count is 2 bits.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  stage can accept; registered, equals (count != 2).
- in_result  input  8  ALU Result.
- in_nzvc  input  4  ALU NZVC, with [3]=N, [2]=Z, [1]=V, [0]=C.
- in_sel  input  3  ALU_Sel that produced the operand; [2]=1 means logic op.
- out_valid  output  1  head entry present (count != 0).
- out_ready  input  1  consumer takes head entry.
- out_result  output  8  head entry result; 8'h00 when empty.
- out_nzvc  output  4  head entry NZVC; 4'h0 when empty.
- out_sel  output  3  head entry select; 3'b000 when empty.
- flags  output  4  architectural NZVC register.
- sticky  output  2  sticky {V,C}; [1]=V, [0]=C.
- clear_sticky  input  1  synchronous clear of sticky.
- count  output  2  occupancy, 0 to 2.

Behaviour:
- Reset (RST=1, asynchronous): count=0, read and write pointers=0, both entries=0, flags=4'b0100 (Z set), sticky=2'b00, in_ready=1, out_valid=0. Reset mid-transfer discards all held entries; no partial state survives.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Pushed data appears at the head on the next cycle when the FIFO was empty. Latency is 1 cycle; there is no combinational path from in_* to out_*.
- Push and pop in the same cycle:
  - Count unchanged.
  - Legal at count=1.
  - At count=2 a push is impossible because in_ready=0.
  - At count=0 a pop is impossible because out_valid=0.
- The write pointer toggles on push and the read pointer toggles on pop. Both wrap 1 to 0.
- in_ready and out_valid are decoded from registered count only.
- Flags update on push, not on pop, in program order:
  - Arithmetic push (in_sel[2]=0): flags <= in_nzvc.
  - Logic push (in_sel[2]=1): flags[3:2] <= in_nzvc[3:2]; flags[1:0] hold their previous value, because the ALU forces V and C to 0 for logic ops.
- Sticky update:
  - On an arithmetic push: sticky <= sticky | in_nzvc[1:0].
  - clear_sticky=1 sets sticky to 0, then ORs in the current cycle's arithmetic push, so a new event in the same cycle wins.
  - Logic pushes never change sticky.
- When in_valid=1 and in_ready=0, the input is not accepted and flags/sticky do not change. The upstream holds its data stable until accepted.
- out_* are stable while out_valid=1 and out_ready=0.
- The empty-FIFO output values (0s) are forced via count, not by clearing storage.

Test Plan:
1. Reset then idle -> count=0, in_ready=1, out_valid=0, flags=4'b0100, sticky=00, out_result=8'h00.
2. Push {result=8'h80, nzvc=4'b1010, sel=3'b000} with out_ready=0 -> next cycle out_valid=1, out_result=8'h80, flags=4'b1010, sticky=2'b10, count=1.
3. Push two entries (8'h11, then 8'h22) with out_ready=0, then assert in_valid with 8'h33 -> in_ready=0 and count=2 hold; 8'h33 not accepted. Set out_ready=1 -> 8'h11 then 8'h22 pop in order; after the 8'h11 pop, in_ready=1 and 8'h33 is accepted.
4. At count=1, simultaneous push 8'h44 and pop -> count stays 1 and the head becomes 8'h44 next cycle. Repeat 4 times to check pointer wrap.
5. flags=4'b0011, push logic op (sel=3'b100, nzvc=4'b0100) -> flags=4'b0111. Then push arithmetic nzvc=4'b0001 together with clear_sticky=1 -> sticky=2'b01.
6. Assert RST asynchronously mid-cycle at count=2 -> outputs take reset values immediately without waiting for a CLK edge. After release, the first push behaves as in scenario 2.
